// File: rtl/hood_button_conditioner.sv
// Range-hood panel button front-end: 2-flop synchronizers, per-channel debounce,
// single-cycle press pulses for the level/clean buttons and short/long press
// classification for the power/menu button.
// Optional build macro: MULTI_PRESS_REJECT_EN suppresses pulses while any other
// debounced button is held.
module hood_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 2_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 300_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_power_menu,
  input  logic       btn_first,
  input  logic       btn_second,
  input  logic       btn_third,
  input  logic       btn_clean,
  output logic       power_menu_short_press,
  output logic       power_menu_long_press,
  output logic       first_level_press,
  output logic       second_level_press,
  output logic       third_level_press,
  output logic       self_clean_press,
  output logic [4:0] btn_stable
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LongMax = 32'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StLongDone} pm_state_e;

  logic [4:0] raw;
  logic [4:0] sync1_q, sync2_q;
  logic [4:0] stable_q, stable_d, stable_prev_q;
  logic [DbW-1:0] db_cnt_q [5];
  logic [DbW-1:0] db_cnt_d [5];
  logic [4:0] rise;
  logic [4:0] others_held;
  logic [3:0] level_pulse_q, level_pulse_d;
  pm_state_e state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic short_q, short_d, long_q, long_d;

  // Bit order matches btn_stable: {clean, third, second, first, power_menu}.
  assign raw = {btn_clean, btn_third, btn_second, btn_first, btn_power_menu};

  // Two-flop synchronizer on every raw input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: flip the stable level only after a long enough run of mismatch.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbMax) begin
        stable_d[i] = ~stable_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Debounced level, its one-cycle-delayed copy for edge detection, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q      <= '0;
      stable_prev_q <= '0;
      db_cnt_q      <= '{default: '0};
    end else begin
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_cnt_q      <= db_cnt_d;
    end
  end

  assign rise = stable_q & ~stable_prev_q;

  // Per channel: is any debounced button other than this one currently held.
  always_comb begin
    others_held = '0;
`ifdef MULTI_PRESS_REJECT_EN
    for (int i = 0; i < 5; i++) begin
      logic [4:0] mask;
      mask        = stable_q;
      mask[i]     = 1'b0;
      others_held[i] = |mask;
    end
`endif
  end

  // Level/clean press pulses on the debounced rising edge.
  always_comb begin
    level_pulse_d = rise[4:1] & ~others_held[4:1];
  end

  // Power/menu press classification: next state and pulse outputs.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (rise[0] && !others_held[0]) begin
          state_d    = StHeld;
          hold_cnt_d = '0;
        end
      end
      StHeld: begin
        if (others_held[0]) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
          // Threshold checked before release so a tie goes to the long press.
          if (hold_cnt_d == LongMax) begin
            long_d  = 1'b1;
            state_d = StLongDone;
          end else if (!stable_q[0]) begin
            short_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StLongDone: begin
        if (!stable_q[0]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state, hold counter and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      hold_cnt_q    <= '0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
      level_pulse_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      short_q       <= short_d;
      long_q        <= long_d;
      level_pulse_q <= level_pulse_d;
    end
  end

  assign power_menu_short_press = short_q;
  assign power_menu_long_press  = long_q;
  assign first_level_press      = level_pulse_q[0];
  assign second_level_press     = level_pulse_q[1];
  assign third_level_press      = level_pulse_q[2];
  assign self_clean_press       = level_pulse_q[3];
  assign btn_stable             = stable_q;

endmodule

// File: tb/tb_hood_button_conditioner.sv
// Directed bench for hood_button_conditioner with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=20. Expected cycle positions are hand-computed from the
// raw edge: btn_stable changes 6 edges later, level pulses at edge 7, the long
// pulse 20 edges after btn_stable rises.
module tb_hood_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_power_menu = 1'b0;
  logic       btn_first = 1'b0;
  logic       btn_second = 1'b0;
  logic       btn_third = 1'b0;
  logic       btn_clean = 1'b0;
  logic       power_menu_short_press;
  logic       power_menu_long_press;
  logic       first_level_press;
  logic       second_level_press;
  logic       third_level_press;
  logic       self_clean_press;
  logic [4:0] btn_stable;

  int checks = 0;
  int errors = 0;

  // Pulse tallies, written only by the monitor below.
  int n_short = 0, n_long = 0, n_first = 0, n_second = 0, n_third = 0, n_clean = 0;

  hood_button_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .btn_power_menu        (btn_power_menu),
    .btn_first             (btn_first),
    .btn_second            (btn_second),
    .btn_third             (btn_third),
    .btn_clean             (btn_clean),
    .power_menu_short_press(power_menu_short_press),
    .power_menu_long_press (power_menu_long_press),
    .first_level_press     (first_level_press),
    .second_level_press    (second_level_press),
    .third_level_press     (third_level_press),
    .self_clean_press      (self_clean_press),
    .btn_stable            (btn_stable)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (power_menu_short_press) n_short++;
    if (power_menu_long_press)  n_long++;
    if (first_level_press)      n_first++;
    if (second_level_press)     n_second++;
    if (third_level_press)      n_third++;
    if (self_clean_press)       n_clean++;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] pulses();
    return {self_clean_press, third_level_press, second_level_press, first_level_press,
            power_menu_long_press, power_menu_short_press};
  endfunction

  initial begin
    int base_a, base_b;
    logic seen;

    // Reset state.
    #1;
    chk("reset_stable", 32'(btn_stable), 32'd0);
    chk("reset_pulses", 32'(pulses()), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Glitch: 3 cycles high must not pass the debouncer.
    base_a = n_first;
    seen = 1'b0;
    btn_first = 1'b1;
    tick(3);
    btn_first = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      seen = seen | btn_stable[1];
    end
    chk("glitch_stable", 32'(seen), 32'd0);
    chk("glitch_pulse", 32'(n_first - base_a), 32'd0);

    // Level press: btn_stable at edge 6, one pulse at edge 7, none on release.
    base_a = n_second;
    btn_second = 1'b1;
    tick(5);
    chk("lvl_stable_e5", 32'(btn_stable), 32'd0);
    tick(1);
    chk("lvl_stable_e6", 32'(btn_stable), 32'b00100);
    chk("lvl_pulse_e6", 32'(second_level_press), 32'd0);
    tick(1);
    chk("lvl_pulse_e7", 32'(second_level_press), 32'd1);
    tick(1);
    chk("lvl_pulse_e8", 32'(second_level_press), 32'd0);
    tick(42);
    btn_second = 1'b0;
    tick(15);
    chk("lvl_release_stable", 32'(btn_stable), 32'd0);
    chk("lvl_pulse_count", 32'(n_second - base_a), 32'd1);

    // Short press: 10 cycles high, stable falls at edge 16, short pulse at 17.
    base_a = n_short;
    base_b = n_long;
    btn_power_menu = 1'b1;
    tick(10);
    btn_power_menu = 1'b0;
    tick(5);
    chk("short_stable_e15", 32'(btn_stable), 32'b00001);
    tick(1);
    chk("short_stable_e16", 32'(btn_stable), 32'd0);
    chk("short_pulse_e16", 32'(power_menu_short_press), 32'd0);
    tick(1);
    chk("short_pulse_e17", 32'(power_menu_short_press), 32'd1);
    chk("short_no_long", 32'(power_menu_long_press), 32'd0);
    tick(30);
    chk("short_count", 32'(n_short - base_a), 32'd1);
    chk("short_long_count", 32'(n_long - base_b), 32'd0);

    // Long press: stable rises at edge 6, long pulse at edge 26.
    base_a = n_short;
    base_b = n_long;
    btn_power_menu = 1'b1;
    tick(25);
    chk("long_pulse_e25", 32'(power_menu_long_press), 32'd0);
    tick(1);
    chk("long_pulse_e26", 32'(power_menu_long_press), 32'd1);
    tick(1);
    chk("long_pulse_e27", 32'(power_menu_long_press), 32'd0);
    tick(33);
    btn_power_menu = 1'b0;
    tick(30);
    chk("long_count", 32'(n_long - base_b), 32'd1);
    chk("long_short_count", 32'(n_short - base_a), 32'd0);

    // Simultaneous press of first and third.
    base_a = n_first;
    base_b = n_third;
    btn_first = 1'b1;
    btn_third = 1'b1;
    tick(7);
`ifdef MULTI_PRESS_REJECT_EN
    chk("simul_first_e7", 32'(first_level_press), 32'd0);
    chk("simul_third_e7", 32'(third_level_press), 32'd0);
`else
    chk("simul_first_e7", 32'(first_level_press), 32'd1);
    chk("simul_third_e7", 32'(third_level_press), 32'd1);
`endif
    tick(10);
    btn_first = 1'b0;
    btn_third = 1'b0;
    tick(15);
`ifdef MULTI_PRESS_REJECT_EN
    chk("simul_first_count", 32'(n_first - base_a), 32'd0);
    chk("simul_third_count", 32'(n_third - base_b), 32'd0);
`else
    chk("simul_first_count", 32'(n_first - base_a), 32'd1);
    chk("simul_third_count", 32'(n_third - base_b), 32'd1);
`endif

    // Reset mid-hold: hold count is 12 after edge 19.
    base_a = n_short;
    base_b = n_long;
    btn_power_menu = 1'b1;
    tick(19);
    rst_n = 1'b0;
    #1;
    chk("rst_async_stable", 32'(btn_stable), 32'd0);
    chk("rst_async_pulses", 32'(pulses()), 32'd0);
    tick(2);
    rst_n = 1'b1;
    chk("rst_no_pulse", 32'((n_long - base_b) + (n_short - base_a)), 32'd0);
    tick(5);
    chk("rst_stable_e5", 32'(btn_stable), 32'd0);
    tick(1);
    chk("rst_stable_e6", 32'(btn_stable), 32'b00001);
    tick(19);
    chk("rst_long_e25", 32'(power_menu_long_press), 32'd0);
    tick(1);
    chk("rst_long_e26", 32'(power_menu_long_press), 32'd1);
    tick(10);
    btn_power_menu = 1'b0;
    tick(20);
    chk("rst_long_count", 32'(n_long - base_b), 32'd1);
    chk("rst_short_count", 32'(n_short - base_a), 32'd0);
    chk("clean_never", 32'(n_clean), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
